// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Combinational two-way round-robin pick; on a tie the side not granted last wins.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic    req_if,
  input  logic    req_dm,
  input  req_id_t last_gnt,
  output logic    gnt_if,
  output logic    gnt_dm
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (req_if && req_dm) begin
      if (last_gnt == REQ_IF) gnt_dm = 1'b1;
      else                    gnt_if = 1'b1;
    end else begin
      gnt_if = req_if;
      gnt_dm = req_dm;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store,
// one transaction at a time, with a fixed memory read latency.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  req_id_t           last_gnt;
  req_id_t           owner;
  logic              cap_wr;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              pick_if, pick_dm;
  logic              arb_ok, any_gnt, cnt_done;

  mem_arb_rr2 u_rr2 (
    .req_if   (if_req),
    .req_dm   (dm_req),
    .last_gnt (last_gnt),
    .gnt_if   (pick_if),
    .gnt_dm   (pick_dm)
  );

  // Grants are only offered while no access is in flight, and never during reset.
  assign arb_ok   = !reset && (state == IDLE || state == RESP);
  assign if_gnt   = arb_ok && pick_if;
  assign dm_gnt   = arb_ok && pick_dm;
  assign any_gnt  = if_gnt || dm_gnt;
  assign cnt_done = (cnt == LAT_C);

  assign mem_en    = (state == ISSUE);
  assign mem_wr    = (state == ISSUE) && cap_wr;
  assign mem_addr  = cap_addr;
  assign mem_wdata = cap_wdata;
  assign if_valid  = (state == RESP) && (owner == REQ_IF);
  assign dm_valid  = (state == RESP) && (owner == REQ_DM);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_gnt) state_nxt = ISSUE;
      ISSUE:   state_nxt = cap_wr ? RESP : WAIT;
      WAIT:    if (cnt_done) state_nxt = RESP;
      RESP:    state_nxt = any_gnt ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= REQ_IF;
      owner     <= REQ_IF;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_nxt;

      if (any_gnt) begin
        owner     <= dm_gnt ? REQ_DM : REQ_IF;
        last_gnt  <= dm_gnt ? REQ_DM : REQ_IF;
        cap_wr    <= dm_gnt && dm_wr;
        cap_addr  <= dm_gnt ? dm_addr : if_addr;
        cap_wdata <= dm_wdata;
      end

      if (state == ISSUE)                 cnt <= CNT_W'(1);
      else if (state == WAIT && !cnt_done) cnt <= cnt + CNT_W'(1);
      else                                cnt <= '0;

      // Read data lands only in the owner's register; the other side keeps its last word.
      if (state == WAIT && cnt_done) begin
        if (owner == REQ_IF) if_rdata <= mem_rdata;
        else                 dm_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 64-bit memory port between the instruction-fetch requester (read-only) and the data requester (ld/sd). It accepts one transaction at a time and arbitrates between the two sides round-robin. It drives the memory with a fixed read latency and returns a one-cycle completion pulse with registered read data to the winning side. It sits between the multicycle control unit / datapath and the memory.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.
- `MEM_LAT`, default 2: memory read latency in cycles, from the address cycle to the data-valid cycle; must be ≥ 1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address; sampled in the `if_gnt` cycle.
- `if_gnt`  out  1  fetch request accepted in this cycle.
- `if_valid`  out  1  one-cycle pulse; `if_rdata` is updated.
- `if_rdata`  out  DATA_W  last fetched word; held until the next fetch completes.
- `dm_req`  in  1  data request; held until `dm_gnt`.
- `dm_wr`  in  1  1 = store, 0 = load; sampled in the `dm_gnt` cycle.
- `dm_addr`  in  ADDR_W  data address; sampled in the `dm_gnt` cycle.
- `dm_wdata`  in  DATA_W  store data; sampled in the `dm_gnt` cycle.
- `dm_gnt`  out  1  data request accepted.
- `dm_valid`  out  1  one-cycle completion pulse for a load or a store.
- `dm_rdata`  out  DATA_W  last loaded word; held until the next load completes.
- `mem_en`  out  1  memory access strobe.
- `mem_wr`  out  1  memory write; asserted only together with `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid MEM_LAT cycles after the `mem_en` cycle.

## Operation
- **States:**
  - IDLE → ISSUE on any accepted request.
  - ISSUE → RESP for a store; ISSUE → WAIT for a read.
  - WAIT → RESP when the counter reaches MEM_LAT.
  - RESP → ISSUE if a request is accepted in RESP, else RESP → IDLE.
- **Arbitration** happens only in IDLE and RESP, and is combinational on the requests.
  - A single requester wins.
  - If both request, the side not granted last wins.
  - `last_gnt` resets to IF, so DM wins the first tie.
  - `gnt` is high in the accept cycle only.
  - Requests arriving in ISSUE/WAIT get no `gnt` and must stay asserted.
- **Capture:** at the end of the `gnt` cycle, latch owner, wr, addr, wdata. Fetches are always reads.
- **ISSUE:** `mem_en` = 1, `mem_wr` = captured wr, `mem_addr`/`mem_wdata` = captured values. These are driven from registers. Outside ISSUE, `mem_en` = `mem_wr` = 0 and addr/wdata hold their values.
- **WAIT:** the counter (width $clog2(MEM_LAT+1)) counts from 1 to MEM_LAT. In the last WAIT cycle, `mem_rdata` is latched into the owner's rdata register only; the other side's rdata is untouched.
- **RESP:** the owner's `valid` = 1 for exactly one cycle. `if_valid` and `dm_valid` are never high together.
- **Reset values:**
  - state IDLE, counter 0, `last_gnt` = IF.
  - All `gnt`/`valid` = 0; `if_rdata` = `dm_rdata` = 0.
  - `mem_en` = `mem_wr` = 0; `mem_addr` = `mem_wdata` = 0.
- **Reset mid-transaction:** the in-flight access is dropped and no `valid` is produced for it. A store already issued is not undone.

## Timing
- Request granted in cycle T:
  - ISSUE at T+1.
  - Read: WAIT for T+2..T+1+MEM_LAT, `valid` at T+2+MEM_LAT.
  - Store: `valid` at T+2.
- The next grant can occur in the RESP cycle. Back-to-back reads therefore run one per MEM_LAT+2 cycles, and back-to-back stores one per 2 cycles.
- `gnt` depends combinationally on `req` and state. `valid`, `rdata` and all `mem_*` outputs are registered or state-decoded with no input-to-output path.

## Structure
- Package `mem_arb_pkg` holds:
  - enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP}
  - enum `req_id_t` {REQ_IF = 0, REQ_DM = 1}
- Sub-module `mem_arb_rr2`: a combinational two-way round-robin pick taking (req_if, req_dm, last_gnt) and producing (gnt_if, gnt_dm). The `last_gnt` register stays in `mem_arbiter`.

## Test plan
All scenarios use MEM_LAT = 2.
- **Fetch:** `if_req` at cycle 0 with addr 0x40, memory returns 0x00500093 → `if_gnt` @0, `mem_en` @1 with addr 0x40, `if_valid` @4 with `if_rdata` = 0x00500093, `dm_rdata` unchanged.
- **Store:** `dm_req`, wr = 1, addr 0x100, wdata 0xDEADBEEF @0 → `mem_en` = `mem_wr` = 1 @1 with those values, `dm_valid` @2, no WAIT.
- **Tie:** both request @0 after reset → DM granted @0; IF still requesting → IF granted at DM's RESP cycle; the next tie goes to DM.
- **Busy:** `if_req` raised during a DM read's WAIT → no `if_gnt` until RESP; the fetch completes with `if_valid` MEM_LAT+2 cycles after its grant.
- **Reset mid-read:** `reset` asserted in the first WAIT cycle → next cycle all outputs at reset values; no `valid` ever appears for that read; a new request is granted normally.
- **Latency sweep:** MEM_LAT = 1 and MEM_LAT = 4 → read `valid` at T+3 and T+6 respectively.
